// File: rtl/dbg_probe_mux.sv
// dbg_probe_mux: registered debug display selector.
// Picks one LED_W-bit slice of NCH probe words for the board LEDs. The slice
// comes from the select input, from an auto-scan sequencer, or from a frozen
// snapshot of the probe bus taken on a trigger.
// Optional feature macro: DBG_AUTOSCAN_EN compiles in the auto-scan divider
// and scan index. Without it, mode 01 behaves exactly like direct mode.
// Handshake: none. Every input is level-sampled on the rising clock edge.
module dbg_probe_mux #(
   parameter int NCH      = 4,
   parameter int W        = 32,
   parameter int LED_W    = 16,
   parameter int SCAN_DIV = 8,
   localparam int S       = W / LED_W,
   localparam int CW      = $clog2(NCH),
   localparam int SW      = (S > 1) ? $clog2(S) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*W-1:0]     probe_bus,
   input  logic [CW+SW-1:0]     sel,
   input  logic [1:0]           mode,
   input  logic                 trig,
   input  logic                 clr,
   output logic [LED_W-1:0]     Led_out,
   output logic [CW+SW-1:0]     cur_sel,
   output logic                 frozen
);

   localparam int NSL = NCH * S;
   localparam int IW  = $clog2(NSL);

   logic [NCH*W-1:0] snapshot;
   logic [NCH*W-1:0] src;
   logic [LED_W-1:0] src_sl [NSL];
   logic [CW-1:0]    idx_ch;
   logic [SW-1:0]    idx_sl;
   logic [IW-1:0]    idx_lin;
   logic [LED_W-1:0] disp_val;
   logic             mode_frz;

   assign mode_frz = (mode == 2'b10);

   // While frozen, the display reads the snapshot instead of the live bus.
   assign src = frozen ? snapshot : probe_bus;

   // Flat view of the source: one entry per slice, channel-major order.
   for (genvar g = 0; g < NSL; g++) begin : g_slice
      assign src_sl[g] = src[g*LED_W +: LED_W];
   end

`ifdef DBG_AUTOSCAN_EN
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DW-1:0] scan_div;
   logic [CW-1:0] scan_ch;
   logic [SW-1:0] scan_sl;
   logic          auto_mode;

   assign auto_mode = (mode == 2'b01);

   // Scan sequencer: hold each slice SCAN_DIV cycles, then step slice-first.
   // Held at {0,0} outside auto-scan so that every entry starts from the top.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_div <= '0;
         scan_ch  <= '0;
         scan_sl  <= '0;
      end else if (!auto_mode) begin
         scan_div <= '0;
         scan_ch  <= '0;
         scan_sl  <= '0;
      end else if (scan_div == DW'(SCAN_DIV - 1)) begin
         scan_div <= '0;
         if (scan_sl == SW'(S - 1)) begin
            scan_sl <= '0;
            scan_ch <= (scan_ch == CW'(NCH - 1)) ? '0 : scan_ch + CW'(1);
         end else begin
            scan_sl <= scan_sl + SW'(1);
         end
      end else begin
         scan_div <= scan_div + DW'(1);
      end
   end

   // Display index: the scan index in auto-scan, the select input otherwise.
   always_comb begin
      idx_ch = sel[CW+SW-1:SW];
      idx_sl = sel[SW-1:0];
      if (auto_mode) begin
         idx_ch = scan_ch;
         idx_sl = scan_sl;
      end
   end
`else
   // Display index comes straight from the select input.
   always_comb begin
      idx_ch = sel[CW+SW-1:SW];
      idx_sl = sel[SW-1:0];
   end
`endif

   // Slice lookup. An index with no backing data displays all ones.
   always_comb begin
      disp_val = '1;
      idx_lin  = '0;
      if ((int'(idx_ch) < NCH) && (int'(idx_sl) < S)) begin
         idx_lin  = IW'(int'(idx_ch) * S + int'(idx_sl));
         disp_val = src_sl[idx_lin];
      end
   end

   // Freeze control. The first trigger captures the bus. A clear, or leaving
   // freeze mode, releases it; on a clear/trigger collision the clear wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frozen   <= 1'b0;
         snapshot <= '0;
      end else if (!mode_frz || clr) begin
         frozen   <= 1'b0;
      end else if (!frozen && trig) begin
         frozen   <= 1'b1;
         snapshot <= probe_bus;
      end
   end

   // Output register. The value and its index are registered together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Led_out <= '0;
         cur_sel <= '0;
      end else begin
         Led_out <= disp_val;
         cur_sel <= {idx_ch, idx_sl};
      end
   end

endmodule

// File: tb/tb_dbg_probe_mux.sv
// tb_dbg_probe_mux: directed, table-driven bench for dbg_probe_mux.
// Two instances share the stimulus: NCH=4 for the main checks and NCH=3 for
// the out-of-range channel behaviour. Both use SCAN_DIV=2.
module tb_dbg_probe_mux;

  localparam logic [127:0] P1 = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h1234_ABCD, 32'h0000_0042};
  localparam logic [127:0] P2 = {32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA, 32'hBBBB_CCCC};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] probe_bus;
  logic [2:0]   sel;
  logic [1:0]   mode;
  logic         trig;
  logic         clr;
  logic [15:0]  led4, led3;
  logic [2:0]   cur4, cur3;
  logic         frz4, frz3;

  dbg_probe_mux #(.NCH(4), .W(32), .LED_W(16), .SCAN_DIV(2)) dut4 (
    .clk(clk), .rst(rst), .probe_bus(probe_bus), .sel(sel), .mode(mode),
    .trig(trig), .clr(clr), .Led_out(led4), .cur_sel(cur4), .frozen(frz4)
  );

  dbg_probe_mux #(.NCH(3), .W(32), .LED_W(16), .SCAN_DIV(2)) dut3 (
    .clk(clk), .rst(rst), .probe_bus(probe_bus[95:0]), .sel(sel), .mode(mode),
    .trig(trig), .clr(clr), .Led_out(led3), .cur_sel(cur3), .frozen(frz3)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act);
    logic [31:0] exp_v;
    exp_v = exp_q.pop_front();
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [1:0] m, input logic [2:0] s, input logic t,
                       input logic c, input logic [127:0] b);
    mode = m; sel = s; trig = t; clr = c; probe_bus = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  sel;
    logic        trig;
    logic        clr;
    logic        alt;
    logic [15:0] led;
    logic        fz;
  } vec_t;

  vec_t vecs[17];
  logic [15:0] p1_sl[8];
  logic [2:0]  exp_idx;
  logic [15:0] exp3;

  initial begin
    // slices of P1, indexed by {channel, slice}
    p1_sl = '{16'h0042, 16'h0000, 16'hABCD, 16'h1234,
              16'hBEEF, 16'hDEAD, 16'hF00D, 16'hCAFE};

    //          mode   sel    trg   clr   alt   led       fz
    vecs[0]  = '{2'b00, 3'b011, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0};
    vecs[1]  = '{2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 16'hABCD, 1'b0};
    vecs[2]  = '{2'b00, 3'b111, 1'b0, 1'b0, 1'b0, 16'hCAFE, 1'b0};
    vecs[3]  = '{2'b00, 3'b100, 1'b0, 1'b0, 1'b1, 16'h8888, 1'b0};
    vecs[4]  = '{2'b11, 3'b001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b0};
    vecs[6]  = '{2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 16'h0042, 1'b1}; // capture P1
    vecs[7]  = '{2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b1}; // snapshot, not live
    vecs[8]  = '{2'b10, 3'b110, 1'b1, 1'b0, 1'b1, 16'hF00D, 1'b1}; // second trig ignored
    vecs[9]  = '{2'b10, 3'b000, 1'b1, 1'b1, 1'b1, 16'h0042, 1'b0}; // clr wins over trig
    vecs[10] = '{2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 16'hCCCC, 1'b0}; // live again
    vecs[11] = '{2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 16'h0042, 1'b0}; // capture suppressed
    vecs[12] = '{2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 16'hCCCC, 1'b0};
    vecs[13] = '{2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 16'h0042, 1'b1}; // capture P1
    vecs[14] = '{2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0}; // mode exit releases
    vecs[15] = '{2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 16'hCCCC, 1'b0};
    vecs[16] = '{2'b00, 3'b001, 1'b1, 1'b0, 1'b1, 16'hBBBB, 1'b0}; // trig ignored in direct

    // reset with a busy bus
    drive(2'b00, 3'b011, 1'b0, 1'b0, P1);
    #12;
    exp_q.push_back(32'h0); chk("reset led4", {16'h0, led4});
    exp_q.push_back(32'h0); chk("reset cur4", {29'h0, cur4});
    exp_q.push_back(32'h0); chk("reset frz4", {31'h0, frz4});
    exp_q.push_back(32'h0); chk("reset led3", {16'h0, led3});
    tick();
    rst = 1'b1;

    // table-driven vectors
    foreach (vecs[i]) begin
      drive(vecs[i].mode, vecs[i].sel, vecs[i].trig, vecs[i].clr, vecs[i].alt ? P2 : P1);
      tick();
      exp3 = (vecs[i].sel[2:1] == 2'd3) ? 16'hFFFF : vecs[i].led;
      exp_q.push_back({16'h0, vecs[i].led}); chk($sformatf("vec%0d led", i), {16'h0, led4});
      exp_q.push_back({29'h0, vecs[i].sel}); chk($sformatf("vec%0d cur_sel", i), {29'h0, cur4});
      exp_q.push_back({31'h0, vecs[i].fz});  chk($sformatf("vec%0d frozen", i), {31'h0, frz4});
      exp_q.push_back({16'h0, exp3});        chk($sformatf("vec%0d led nch3", i), {16'h0, led3});
    end
    exp_q.push_back({29'h0, 3'b001}); chk("nch3 cur_sel", {29'h0, cur3});

    // auto-scan: full sweep plus wrap
    drive(2'b01, 3'b011, 1'b0, 1'b0, P1);
    for (int i = 0; i < 18; i++) begin
      tick();
`ifdef DBG_AUTOSCAN_EN
      exp_idx = 3'((i / 2) % 8);
`else
      exp_idx = 3'b011;
`endif
      exp_q.push_back({29'h0, exp_idx});      chk($sformatf("scan%0d cur_sel", i), {29'h0, cur4});
      exp_q.push_back({16'h0, p1_sl[exp_idx]}); chk($sformatf("scan%0d led", i), {16'h0, led4});
    end

    // async reset in the middle of a scan at index {2,1}
    drive(2'b00, 3'b101, 1'b0, 1'b0, P1);
    tick();
    mode = 2'b01;
    for (int i = 0; i < 11; i++) tick();
`ifdef DBG_AUTOSCAN_EN
    exp_idx = 3'b101;
`else
    exp_idx = sel;
`endif
    exp_q.push_back({29'h0, exp_idx}); chk("pre-reset cur_sel", {29'h0, cur4});
    #1 rst = 1'b0;
    #1;
    exp_q.push_back(32'h0); chk("async led", {16'h0, led4});
    exp_q.push_back(32'h0); chk("async cur_sel", {29'h0, cur4});
    exp_q.push_back(32'h0); chk("async frozen", {31'h0, frz4});
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef DBG_AUTOSCAN_EN
      exp_idx = (i < 2) ? 3'b000 : 3'b001;
`else
      exp_idx = 3'b101;
`endif
      exp_q.push_back({29'h0, exp_idx}); chk($sformatf("restart%0d cur_sel", i), {29'h0, cur4});
      exp_q.push_back({16'h0, p1_sl[exp_idx]}); chk($sformatf("restart%0d led", i), {16'h0, led4});
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbg_probe_mux.md
# dbg_probe_mux

Parametrised debug display selector between the processor datapath and the board LEDs/bench monitor. Samples NCH probe words (PC, instruction, ALU result, register data, ...) of width W and drives one LED_W-bit slice onto `Led_out`, chosen directly by a select input, by an automatic scan sequencer, or from a frozen snapshot taken on a trigger. It is the generalised, registered successor of the fixed 2-bit `ledSel` / 16-bit LED path, and gives the pipelined datapath a stable observation point.

## Interface
- `NCH`, 4: number of probe channels, ≥2.
- `W`, 32: probe word width; must be an integer multiple of LED_W.
- `LED_W`, 16: display width.
- `SCAN_DIV`, 8: cycles each slice is held in auto-scan, ≥1.
- Derived: S = W/LED_W slices per channel; CW = clog2(NCH); SW = max(1, clog2(S)).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `probe_bus` in NCH*W: channel k occupies bits [k*W +: W].
- `sel` in CW+SW: {channel, slice}; slice 0 = least significant LED_W bits.
- `mode` in 2: 00 direct, 01 auto-scan, 10 freeze-on-trigger, 11 reserved (behaves as 00).
- `trig` in 1: freeze trigger, level-sampled.
- `clr` in 1: release frozen snapshot.
- `Led_out` out LED_W: registered display value.
- `cur_sel` out CW+SW: {channel, slice} currently displayed, registered with `Led_out`.
- `frozen` out 1: snapshot held.

## Operation
- Reset (rst low, async): `Led_out`=0, `cur_sel`=0, `frozen`=0, scan index=0, scan divider=0, snapshot=0.
- Source index: direct/freeze modes use `sel`; auto-scan uses internal scan index.
- Data source: live `probe_bus` unless `frozen`=1, then the snapshot register (NCH*W bits).
- Out-of-range channel (channel field ≥ NCH): `Led_out` = all ones; `cur_sel` still reflects the index.
- Auto-scan: divider counts 0..SCAN_DIV-1; on terminal count scan index advances through slice 0..S-1 of channel 0, then channel 1, ... channel NCH-1 slice S-1, wraps to 0. Divider and index reset to 0 whenever mode is not 01, so entering auto-scan always starts at {0,0}.
- Freeze: in mode 10 with `frozen`=0 and `trig`=1 at an edge, snapshot ← `probe_bus`, `frozen` ← 1 at that edge. Further triggers while frozen are ignored (first trigger wins).
- Release: `clr`=1, or mode ≠ 10, clears `frozen` at the next edge; snapshot content is retained but unused. `clr` and `trig` in the same cycle while frozen: release wins; while not frozen: capture is suppressed.
- Mode change mid-scan or mid-freeze takes effect on the next edge; no glitch states.

## Timing
- Direct mode: `Led_out`/`cur_sel` reflect `sel` and `probe_bus` sampled at edge n, visible after edge n (1-cycle latency).
- Freeze: snapshot and `frozen` update at trigger edge n; `Led_out` shows snapshot data from edge n+1.
- Auto-scan: each index displayed for exactly SCAN_DIV cycles; full sweep = NCH*S*SCAN_DIV cycles. First index {0,0} appears at the edge after mode becomes 01.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously); operation resumes on first edge after release.

## Configuration
- `DBG_AUTOSCAN_EN` defined: divider, scan index and mode 01 behaviour compiled in as above.
- Not defined: no scan counters synthesised; mode 01 behaves exactly as mode 00 (direct).

## Test plan
- Reset: rst low with probe_bus nonzero -> `Led_out`=0, `cur_sel`=0, `frozen`=0; release, mode 00, sel={1,1}, channel 1=32'h1234_ABCD -> `Led_out`=16'h1234 one cycle later.
- Out of range: NCH=3, sel channel 3 -> `Led_out`=16'hFFFF.
- Auto-scan (macro on, SCAN_DIV=2, NCH=4): mode 01 -> `cur_sel` sequence {0,0},{0,1},{1,0},... each held 2 cycles, wraps to {0,0} after 16 cycles; without macro -> `cur_sel` tracks `sel`.
- Freeze: mode 10, channel 0=32'h0000_0042, trig pulse, then probe_bus changes -> `frozen`=1, `Led_out` stays 16'h0042; second trig ignored.
- Release conflict: frozen, clr=1 and trig=1 same cycle -> `frozen`=0 next edge, live data shown; mode change 10->00 also clears `frozen`.
- Async reset during scan at index {2,1} -> outputs zero without clock edge; scan restarts at {0,0}.
